// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order prefetch queue, redirect/drain.
// Optional jump predecode is enabled by defining IFU_JUMP_PREDECODE_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_pred_taken
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, out_nxt, q_count;
  logic [CW:0]   credit_used;

  logic [31:0]   q_instr [BUF_DEPTH];
  logic [31:0]   q_pc    [BUF_DEPTH];
  logic          q_pred  [BUF_DEPTH];
  logic [PW-1:0] q_rd, q_wr;

  // PCs of accepted-but-unanswered requests, in issue order
  logic [31:0]   p_pc [BUF_DEPTH];
  logic [PW-1:0] p_rd, p_wr;

  logic        accept, resp, push, pop, pd_redirect;
  logic [31:0] resp_pc, pd_target;

  assign credit_used = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req    = (state == FETCH) && (credit_used < (CW+1)'(BUF_DEPTH));
  assign imem_addr   = fetch_pc;

  assign accept  = imem_req & imem_ready;
  // Stray responses after a mid-flight reset are ignored rather than underflowing the count
  assign resp    = imem_rvalid & (outstanding != '0);
  assign resp_pc = p_pc[p_rd];
  assign push    = resp & (state == FETCH) & ~redirect;
  assign pop     = instr_valid & ~stall & ~redirect;
  assign out_nxt = outstanding + CW'(accept) - CW'(resp);

`ifdef IFU_JUMP_PREDECODE_EN
  logic [31:0] pc_plus4;
  assign pc_plus4    = resp_pc + 32'd4;
  assign pd_redirect = push && (imem_rdata[31:26] == 6'b000010);
  assign pd_target   = (pc_plus4 & 32'hF000_0000) | {4'b0000, imem_rdata[25:0], 2'b00};
`else
  assign pd_redirect = 1'b0;
  assign pd_target   = 32'h0000_0000;
`endif

  assign instr_valid      = (q_count != '0);
  assign instr            = q_instr[q_rd];
  assign instr_pc         = q_pc[q_rd];
  assign instr_pred_taken = q_pred[q_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if ((redirect || pd_redirect) && (out_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (out_nxt == '0) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      p_rd        <= '0;
      p_wr        <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_count     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_pred[i]  <= 1'b0;
        p_pc[i]    <= '0;
      end
    end else begin
      outstanding <= out_nxt;
      if (accept) begin
        p_pc[p_wr] <= fetch_pc;
        p_wr       <= p_wr + PW'(1);
      end
      if (resp) p_rd <= p_rd + PW'(1);

      if (redirect)         fetch_pc <= redirect_pc & ~32'h3;
      else if (pd_redirect) fetch_pc <= pd_target;
      else if (accept)      fetch_pc <= fetch_pc + 32'd4;

      if (redirect) begin
        q_rd    <= '0;
        q_wr    <= '0;
        q_count <= '0;
      end else begin
        if (push) begin
          q_instr[q_wr] <= imem_rdata;
          q_pc[q_wr]    <= resp_pc;
          q_pred[q_wr]  <= pd_redirect;
          q_wr          <= q_wr + PW'(1);
        end
        if (pop) q_rd <= q_rd + PW'(1);
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit: in-order memory model with programmable latency, PC scoreboard.
module tb_instr_fetch_unit;
  logic        clk, rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_pred_taken;
  logic [31:0] instr, instr_pc;

  logic        req2, rvalid2, valid2, pred2;
  logic [31:0] addr2, rdata2, instr2, pc2;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mem_cyc, mem_lat;
  logic        jmp_en;
  logic        r2_pend;
  logic [31:0] r2_addr;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pred_taken(instr_pred_taken)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(imem_ready), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(valid2), .instr(instr2), .instr_pc(pc2),
    .instr_pred_taken(pred2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jmp_en && a == 32'h10) return {6'b000010, 26'h40};
    return a;
  endfunction

  // In-order memory: accept seen in cycle k is answered in cycle k+mem_lat
  always @(negedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      mem_cyc     = 0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      rvalid2     = 1'b0;
      rdata2      = 32'h0;
      r2_pend     = 1'b0;
      r2_addr     = 32'h0;
    end else begin
      imem_rvalid = 1'b0;
      if (mq_due.size() > 0 && mq_due[0] == mem_cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_ready) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(mem_cyc + mem_lat);
      end
      mem_cyc++;
      rvalid2 = r2_pend;
      rdata2  = r2_addr;
      r2_pend = req2 && imem_ready;
      r2_addr = addr2;
    end
  end

  // Leaves the bench at posedge+1 of cycle 0 (first cycle after release)
  task automatic do_reset(input int lat, input logic jmp);
    @(posedge clk); #1;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; mem_lat = lat; jmp_en = jmp;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1; mem_lat = 1; jmp_en = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || instr_pred_taken !== 1'b0)
      $display("FAIL reset_outputs got v=%b i=%h pc=%h p=%b want 0/0/0/0", instr_valid, instr, instr_pc, instr_pred_taken);
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_first_req got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else passed++;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8)
      $display("FAIL reset_pc_param got req=%b addr=%h want 1/fffffff8", req2, addr2);
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1) $display("FAIL midrun_valid got %b want 1", instr_valid);
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1)
      $display("FAIL midrun_reset got v=%b addr=%h req=%b want 0/00000000/1", instr_valid, imem_addr, imem_req);
    else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    do_reset(1, 1'b0);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (c < 2) begin
        checks++;
        if (instr_valid !== 1'b0) $display("FAIL seq_latency cycle %0d got valid=%b want 0", c, instr_valid);
        else passed++;
      end
      if (c == 2) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
          $display("FAIL seq_first got valid=%b pc=%h want 1/00000000", instr_valid, instr_pc);
        else passed++;
      end
      if (instr_valid && !stall && !redirect) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== e || instr_pred_taken !== 1'b0)
          $display("FAIL seq_stream got pc=%h instr=%h p=%b want pc=%h instr=%h p=0", instr_pc, instr, instr_pred_taken, e, e);
        else passed++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL seq_timeout got %0d left want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
    do_reset(1, 1'b0);
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      stall = (c >= 4 && c < 9);
      @(negedge clk);
      if (c == 8) begin
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== exp_q[0])
          $display("FAIL stall_hold got req=%b valid=%b pc=%h want 0/1/%h", imem_req, instr_valid, instr_pc, exp_q[0]);
        else passed++;
      end
      if (instr_valid && !stall && !redirect) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== e)
          $display("FAIL stall_stream got pc=%h instr=%h want %h", instr_pc, instr, e);
        else passed++;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL stall_timeout got %0d left want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_redirect_drain();
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    do_reset(3, 1'b0);
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      redirect    = (c == 2);
      redirect_pc = 32'h103;
      @(negedge clk);
      if (c == 3 || c == 4) begin
        checks++;
        if (imem_req !== 1'b0) $display("FAIL drain_noreq cycle %0d got req=%b want 0", c, imem_req);
        else passed++;
      end
      if (c == 5) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100)
          $display("FAIL drain_restart got req=%b addr=%h want 1/00000100", imem_req, imem_addr);
        else passed++;
      end
      if (instr_valid && !stall && !redirect) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== e)
          $display("FAIL drain_stream got pc=%h instr=%h want %h", instr_pc, instr, e);
        else passed++;
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout got %0d left want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_ready_stall();
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    do_reset(1, 1'b0);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      imem_ready  = (c >= 4);
      redirect    = (c == 2);
      redirect_pc = 32'h200;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
          $display("FAIL ready_hold got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        else passed++;
      end
      if (c == 3) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200)
          $display("FAIL ready_redirect got req=%b addr=%h want 1/00000200", imem_req, imem_addr);
        else passed++;
      end
      if (instr_valid && !stall && !redirect) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== e)
          $display("FAIL ready_stream got pc=%h instr=%h want %h", instr_pc, instr, e);
        else passed++;
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    imem_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0) $display("FAIL ready_timeout got %0d left want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] e;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    do_reset(1, 1'b0);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (req2 && imem_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (addr2 !== e) $display("FAIL wrap_addr got %h want %h", addr2, e);
        else passed++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL wrap_timeout got %0d left want 0", exp_q.size());
    else passed++;
  endtask

`ifdef IFU_JUMP_PREDECODE_EN
  task automatic test_predecode();
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    do_reset(1, 1'b1);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (instr_valid && !stall && !redirect) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== mem_word(e) || instr_pred_taken !== (e == 32'h10))
          $display("FAIL predecode_stream got pc=%h instr=%h p=%b want pc=%h instr=%h p=%b",
                   instr_pc, instr, instr_pred_taken, e, mem_word(e), (e == 32'h10));
        else passed++;
      end
      @(posedge clk); #1;
    end
    jmp_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL predecode_timeout got %0d left want 0", exp_q.size());
    else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; mem_lat = 1; jmp_en = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_ready_stall();
    test_reset_pc_wrap();
`ifdef IFU_JUMP_PREDECODE_EN
    test_predecode();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the pipelined MIPS32 core. It is the producer side of the decode path: it generates sequential PCs and issues requests to instruction memory. It buffers returned words in an in-order prefetch queue and presents one instruction plus PC per cycle to the IF/ID register, whose `instr[31:26]` feeds the control unit's `opcode`. Branch and jump resolution from later stages redirects it through `redirect`/`redirect_pc`.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `BUF_DEPTH`, default 2: prefetch queue entries; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ready`  in  1  memory accepts the request when `imem_req & imem_ready`.
- `imem_rvalid`  in  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- `imem_rdata`  in  32  response instruction word.
- `stall`  in  1  decode stalled (hazard); head is not consumed.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  restart address; bits [1:0] ignored (treated as 0).
- `instr_valid`  out  1  queue head valid.
- `instr`  out  32  queue head instruction.
- `instr_pc`  out  32  PC of queue head.
- `instr_pred_taken`  out  1  head is a jump already redirected by predecode (see Configuration).

## Operation
- State: `fetch_pc`, `outstanding` count (width clog2(BUF_DEPTH)+1), queue (instr, pc, pred flag), FSM {FETCH, DRAIN}.
- Credit: `imem_req = (state==FETCH) & (queue_count + outstanding < BUF_DEPTH)`, using registered counts only. A pop in the same cycle does not add credit.
- Accept (`imem_req & imem_ready`): `outstanding++`, `fetch_pc += 4`. Wrap from `32'hFFFF_FFFC` to `0`.
- Response in FETCH: enqueue `{imem_rdata, pc}` with `pc` tracked per outstanding request; `outstanding--`. The queue cannot overflow because of the credit rule.
- Pop: `instr_valid & ~stall & ~redirect`.
- `redirect` (highest priority):
  - Queue cleared.
  - `fetch_pc <= redirect_pc`.
  - If `outstanding` after this cycle's accept/response is >0, go to DRAIN; otherwise stay in FETCH.
  - A request presented but not accepted in the redirect cycle is abandoned. Its address may change next cycle.
- DRAIN:
  - `imem_req=0`.
  - Each `imem_rvalid` is discarded and decrements `outstanding`.
  - When `outstanding` reaches 0, go to FETCH.
  - A new `redirect` in DRAIN only updates `fetch_pc`.
- `imem_addr = fetch_pc` whenever `imem_req` is high. It is held stable until accepted, except on redirect.

## Timing
- Reset values: `fetch_pc=RESET_PC`, queue empty, `outstanding=0`, state FETCH, `instr_valid=0`, `instr=0`, `instr_pc=0`, `instr_pred_taken=0`. `imem_req` is 1 in the first cycle after reset release.
- Reset asserted mid-operation clears everything immediately. In-flight responses arriving after release are not tracked. Memory must be reset together with this block.
- Latency: a response in cycle N makes `instr_valid` high in N+1 (registered queue, no bypass).
- With 1-cycle memory and `imem_ready=1`: accept in cycle 0 gives `instr_valid` in cycle 2. Steady state delivers one instruction per cycle when `BUF_DEPTH≥2`.
- Redirect in cycle N with nothing outstanding gives `imem_req` with `imem_addr=redirect_pc` in N+1.
- Simultaneous response and pop on a full queue is legal. Simultaneous redirect and response means the response is dropped.

## Configuration
- `IFU_JUMP_PREDECODE_EN` defined: a response accepted in FETCH with `imem_rdata[31:26]==6'b000010` is enqueued with `pred_flag=1`. In the same cycle the fetch redirects internally:
  - `fetch_pc <= {pc_plus4[31:28], imem_rdata[25:0], 2'b00}`.
  - Younger outstanding responses are dropped via DRAIN.
  - Older queue entries are kept.
  - External `redirect` in the same cycle overrides the internal one.
  - Downstream suppresses its own redirect when `instr_pred_taken=1`.
- Not defined: purely sequential fetch; `instr_pred_taken` is tied 0.

## Test plan
- Reset release, 1-cycle memory returning `imem_rdata=addr` → `instr_pc` 0,4,8,12 in consecutive cycles from cycle 2; `instr==instr_pc`.
- `stall=1` for 5 cycles with `BUF_DEPTH=2` → `imem_req` drops after 2 credits are used; no word is lost or duplicated; stream resumes at the correct PC.
- 3-cycle memory latency, `redirect=1`, `redirect_pc=32'h100` with 2 outstanding → both stale responses are discarded in DRAIN; first `instr_pc=32'h100`.
- `RESET_PC=32'hFFFF_FFF8` → fetch addresses FFF8, FFFC, 0000, 0004.
- `imem_ready=0` for 4 cycles → `imem_addr` is stable. A redirect in cycle 2 changes it to the new PC; no spurious instruction appears.
- With `IFU_JUMP_PREDECODE_EN`, `j` at PC `0x10` with target field `0x40` → next `instr_pc` is `0x100`; `instr_pred_taken=1` on the `j` entry only.
